// File: rtl/full_logic_nch_pkg.sv
// Shared defaults and helpers for the N-channel full logic block.
package full_logic_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_AF_THRESH  = 3;
  localparam int unsigned DEF_AE_THRESH  = 1;

  // Counts need one extra bit so a full FIFO (2**ADDR_WIDTH) is representable.
  localparam int unsigned DEF_COUNT_W    = DEF_ADDR_WIDTH + 1;

  function automatic int unsigned count_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Extracts the channel select field word[dw-1 -: sw]; word is zero-extended to 64 bits.
  function automatic int unsigned sel_of(input logic [63:0] word,
                                         input int unsigned dw,
                                         input int unsigned sw);
    logic [63:0] w_mask;
    logic [63:0] w_field;
    w_mask  = (64'd1 << sw) - 64'd1;
    w_field = (word >> (dw - sw)) & w_mask;
    return w_field[31:0];
  endfunction

endpackage

// File: rtl/full_logic_nch_fifo_sync.sv
// Synchronous FIFO with registered pop output, level flags and error pulses.
module fifo_sync
  import full_logic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout_reg,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW    = count_width(ADDR_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full         = (r_count == LP_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign w_do_push    = push & ~full;
  assign w_do_pop     = pop & ~empty;
  assign overflow     = push & full;
  assign underflow    = pop & empty;
  assign head         = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until covered by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered pop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      dout_reg   <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= w_do_pop;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_do_pop) begin
        dout_reg <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/full_logic_nch.sv
// Main FIFO feeding NUM_CH channel FIFOs selected by the word's top bits.
module full_logic_nch
  import full_logic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned SEL_W      = $clog2(NUM_CH),
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_enable,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [NUM_CH-1:0]            pop,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            valid_out,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            almost_empty,
  output logic                         pause,
  output logic                         error_main,
  output logic [NUM_CH-1:0]            error_ch
);

  logic [DATA_WIDTH-1:0] w_main_head;
  logic                  w_main_empty;
  logic                  w_main_af;
  logic                  w_main_overflow;
  logic                  w_xfer;
  logic [SEL_W-1:0]      w_sel;
  logic [NUM_CH-1:0]     w_ch_push;
  logic [NUM_CH-1:0]     w_ch_full;
  logic [NUM_CH-1:0]     w_ch_af;
  logic [NUM_CH-1:0]     w_ch_underflow;

  logic [DATA_WIDTH-1:0] w_main_dout_unused;
  logic                  w_main_dvalid_unused;
  logic                  w_main_full_unused;
  logic                  w_main_ae_unused;
  logic                  w_main_underflow_unused;
  logic [DATA_WIDTH-1:0] w_ch_head_unused [NUM_CH];
  logic [NUM_CH-1:0]     w_ch_overflow_unused;

  logic                  r_error_main;
  logic [NUM_CH-1:0]     r_error_ch;

  fifo_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_main (
    .clk          (clk),
    .reset        (reset),
    .push         (wr_enable),
    .pop          (w_xfer),
    .din          (data_in),
    .dout_reg     (w_main_dout_unused),
    .dout_valid   (w_main_dvalid_unused),
    .head         (w_main_head),
    .full         (w_main_full_unused),
    .empty        (w_main_empty),
    .almost_full  (w_main_af),
    .almost_empty (w_main_ae_unused),
    .overflow     (w_main_overflow),
    .underflow    (w_main_underflow_unused)
  );

  assign w_sel  = SEL_W'(sel_of(64'(w_main_head), DATA_WIDTH, SEL_W));
  // Fullness is the registered level: a full channel popped this cycle still refuses the transfer.
  assign w_xfer = ~w_main_empty & ~w_ch_full[w_sel];

  // Steer the single transfer to the selected channel.
  always_comb begin
    w_ch_push = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_ch_push[i] = w_xfer & (w_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo_sync #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_THRESH  (AF_THRESH),
      .AE_THRESH  (AE_THRESH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .push         (w_ch_push[g]),
      .pop          (pop[g]),
      .din          (w_main_head),
      .dout_reg     (data_out[g*DATA_WIDTH +: DATA_WIDTH]),
      .dout_valid   (valid_out[g]),
      .head         (w_ch_head_unused[g]),
      .full         (w_ch_full[g]),
      .empty        (empty[g]),
      .almost_full  (w_ch_af[g]),
      .almost_empty (almost_empty[g]),
      .overflow     (w_ch_overflow_unused[g]),
      .underflow    (w_ch_underflow[g])
    );
  end

  assign pause      = w_main_af | (|w_ch_af);
  assign error_main = r_error_main;
  assign error_ch   = r_error_ch;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error_main <= 1'b0;
      r_error_ch   <= '0;
    end else begin
      r_error_main <= r_error_main | w_main_overflow;
      r_error_ch   <= r_error_ch | w_ch_underflow;
    end
  end

endmodule

// File: tb/tb_full_logic_nch.sv
// Self-checking bench for full_logic_nch against a queue-based reference model.
module tb_full_logic_nch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_enable = 1'b0;
  logic [5:0]  data_in = '0;
  logic [3:0]  pop = '0;
  logic [23:0] data_out;
  logic [3:0]  valid_out;
  logic [3:0]  empty;
  logic [3:0]  almost_empty;
  logic        pause;
  logic        error_main;
  logic [3:0]  error_ch;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  int       mq[$];
  int       cq[4][$];
  int       m_dout[4];
  bit [3:0] m_valid;
  bit       m_err_main;
  bit [3:0] m_err_ch;

  full_logic_nch #(
    .DATA_WIDTH (6),
    .ADDR_WIDTH (2),
    .NUM_CH     (4),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_enable    (wr_enable),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .almost_empty (almost_empty),
    .pause        (pause),
    .error_main   (error_main),
    .error_ch     (error_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      cq[i].delete();
      m_dout[i] = 0;
    end
    m_valid    = '0;
    m_err_main = 1'b0;
    m_err_ch   = '0;
  endtask

  // One clock edge of behaviour, decided from the state before the edge.
  task automatic model_step(input bit wr, input int d, input bit [3:0] p);
    int pre_m;
    int pre_c[4];
    int s;
    pre_m = mq.size();
    for (int i = 0; i < 4; i++) pre_c[i] = cq[i].size();
    m_valid = '0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (pre_c[i] > 0) begin
          m_dout[i]  = cq[i].pop_front();
          m_valid[i] = 1'b1;
        end else begin
          m_err_ch[i] = 1'b1;
        end
      end
    end
    if (pre_m > 0) begin
      s = mq[0] / 16;
      if (pre_c[s] < 4) cq[s].push_back(mq.pop_front());
    end
    if (wr) begin
      if (pre_m < 4) mq.push_back(d);
      else m_err_main = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] e_do;
    logic [3:0]  e_em;
    logic [3:0]  e_ae;
    bit          e_pause;
    e_do = '0;
    e_pause = (mq.size() >= 3);
    for (int i = 0; i < 4; i++) begin
      e_do[i*6 +: 6] = 6'(m_dout[i]);
      e_em[i] = (cq[i].size() == 0);
      e_ae[i] = (cq[i].size() <= 1);
      if (cq[i].size() >= 3) e_pause = 1'b1;
    end
    chk({tag, ".data_out"}, 32'(data_out), 32'(e_do));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".empty"}, 32'(empty), 32'(e_em));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(e_ae));
    chk({tag, ".pause"}, 32'(pause), 32'(e_pause));
    chk({tag, ".error_main"}, 32'(error_main), 32'(m_err_main));
    chk({tag, ".error_ch"}, 32'(error_ch), 32'(m_err_ch));
  endtask

  task automatic step(input string tag, input bit wr, input logic [5:0] d, input logic [3:0] p);
    @(negedge clk);
    reset = 1'b0; wr_enable = wr; data_in = d; pop = p;
    @(posedge clk);
    #1;
    model_step(wr, int'(d), p);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk);
    reset = 1'b1; wr_enable = 1'b0; data_in = '0; pop = '0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    // Reset state
    do_reset("reset", 3);
    chk("reset.empty_const", 32'(empty), 32'hF);
    chk("reset.data_out_const", 32'(data_out), 32'h0);

    // Routing: one word per channel then pop all four together
    step("route.w0", 1, 6'b000001, 4'b0000);
    step("route.w1", 1, 6'b010010, 4'b0000);
    step("route.w2", 1, 6'b100011, 4'b0000);
    step("route.w3", 1, 6'b110100, 4'b0000);
    step("route.idle", 0, 6'b0, 4'b0000);
    step("route.pop", 0, 6'b0, 4'b1111);
    chk("route.data_out_const", 32'(data_out), 32'({6'h34, 6'h23, 6'h12, 6'h01}));
    chk("route.valid_const", 32'(valid_out), 32'hF);
    step("route.after", 0, 6'b0, 4'b0000);
    chk("route.valid_drop", 32'(valid_out), 32'h0);

    // Backpressure: six ch0 words, no pops
    do_reset("bp.reset", 1);
    for (int i = 1; i <= 6; i++) step("bp.write", 1, 6'(i), 4'b0000);
    step("bp.idle0", 0, 6'b0, 4'b0000);
    step("bp.idle1", 0, 6'b0, 4'b0000);
    chk("bp.pause_const", 32'(pause), 32'h1);
    for (int i = 1; i <= 6; i++) begin
      step("bp.pop", 0, 6'b0, 4'b0001);
      chk("bp.order", 32'(data_out[5:0]), 32'(i));
    end

    // Overflow and head-of-line blocking
    do_reset("ovf.reset", 1);
    for (int i = 1; i <= 4; i++) step("ovf.fill", 1, 6'(i), 4'b0000);
    step("ovf.idle0", 0, 6'b0, 4'b0000);
    step("ovf.idle1", 0, 6'b0, 4'b0000);
    for (int i = 5; i <= 9; i++) step("ovf.over", 1, 6'(i), 4'b0000);
    chk("ovf.error_main_const", 32'(error_main), 32'h1);
    step("ovf.pop1", 0, 6'b0, 4'b0001);
    step("ovf.idle2", 0, 6'b0, 4'b0000);
    step("ovf.w_ch1", 1, 6'b010111, 4'b0000);
    for (int i = 0; i < 3; i++) step("ovf.blocked", 0, 6'b0, 4'b0000);
    chk("ovf.ch1_blocked_const", 32'(empty[1]), 32'h1);
    for (int i = 0; i < 8; i++) step("ovf.drain", 0, 6'b0, 4'b0001);
    chk("ovf.ch1_arrived_const", 32'(empty[1]), 32'h0);

    // Underflow with simultaneous pop and transfer on ch1
    do_reset("udf.reset", 1);
    step("udf.wa", 1, 6'b010001, 4'b0000);
    step("udf.wb", 1, 6'b010010, 4'b0000);
    step("udf.pop", 0, 6'b0, 4'b0110);
    chk("udf.err_ch2_const", 32'(error_ch[2]), 32'h1);
    chk("udf.valid_const", 32'(valid_out), 32'h2);
    chk("udf.ch1_occupied_const", 32'(empty[1]), 32'h0);
    step("udf.pop_b", 0, 6'b0, 4'b0010);
    chk("udf.b_const", 32'(data_out[11:6]), 32'h12);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step("mid.fill", 1, 6'(i + 1), 4'b0000);
    do_reset("mid.reset", 1);
    chk("mid.errors_const", 32'({error_main, error_ch}), 32'h0);
    step("mid.w", 1, 6'b100011, 4'b0000);
    step("mid.idle", 0, 6'b0, 4'b0000);
    step("mid.pop", 0, 6'b0, 4'b0100);
    chk("mid.ch2_const", 32'(data_out[17:12]), 32'h23);

    // Randomized traffic
    do_reset("rnd.reset", 1);
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 99) < 60), 6'($urandom), 4'($urandom & $urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/full_logic_nch.md
# full_logic_nch

Parametrised successor to the two-channel transmission-layer full logic. Words enter a main FIFO and are routed by their top select bits into NUM_CH per-channel output FIFOs. Each channel has its own pop port. The block raises a combined backpressure flag toward the upstream writer and sticky overflow and underflow error flags. It sits between the link-layer write port and the per-lane consumers.

## Interface
- DATA_WIDTH, 6 — word width; the channel select is in the top SEL_W bits.
- ADDR_WIDTH, 2 — FIFO pointer width; every FIFO is 2**ADDR_WIDTH deep.
- NUM_CH, 4 — number of output channels; power of two, ≥2.
- SEL_W, $clog2(NUM_CH) — width of the select field, data[DATA_WIDTH-1 -: SEL_W].
- AF_THRESH, 3 — almost-full when count ≥ AF_THRESH.
- AE_THRESH, 1 — almost-empty when count ≤ AE_THRESH.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_enable  in  1  push data_in into the main FIFO.
- data_in  in  DATA_WIDTH  write word.
- pop  in  NUM_CH  per-channel pop request.
- data_out  out  NUM_CH*DATA_WIDTH  registered channel heads; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  NUM_CH  one-cycle strobe; data_out slice is new.
- empty  out  NUM_CH  channel FIFO empty.
- almost_empty  out  NUM_CH  channel count ≤ AE_THRESH.
- pause  out  1  main FIFO almost-full OR any channel FIFO almost-full.
- error_main  out  1  sticky; a write arrived while the main FIFO was full.
- error_ch  out  NUM_CH  sticky; a pop arrived on an empty channel.

## Operation
- Main FIFO push: wr_enable=1 and main not full → write the word and increment count. If the main FIFO is full, drop the word and set error_main.
- Transfer: one word per cycle moves from the main head to channel sel = head[DATA_WIDTH-1 -: SEL_W]. It moves only when main is not empty and channel sel is not full.
- Head-of-line blocking: if the destination channel is full, the head stalls, and so does every word behind it.
- Fullness is taken from the registered state of the current cycle. There is no bypass: a channel that is full and popped in the same cycle receives no transfer that cycle.
- Pop on channel i when the channel is not empty: the head goes to the data_out slice i, valid_out[i]=1, and the count decrements.
- Pop on channel i when empty: error_ch[i] is set, valid_out[i]=0, and data_out slice i holds its value.
- In the same cycle, pops on several channels and one transfer are all legal. A channel may be both popped and written in one cycle, and its count stays unchanged.
- Main push and transfer in the same cycle: the main count is unchanged.
- Error flags clear only on reset.
- pivot state is not a state machine. Behaviour is counter and pointer based; pointers wrap modulo 2**ADDR_WIDTH.
- Counts are ADDR_WIDTH+1 bits wide. full = count==2**ADDR_WIDTH; empty = count==0.

## Timing
- Reset values: data_out=0, valid_out=0, empty=all 1, almost_empty=all 1, pause=0, error_main=0, error_ch=0. All pointers and counts are 0.
- Write sampled at edge k → word is in the main FIFO after edge k.
- Transfer happens at edge k+1 at the earliest; the channel empty flag deasserts after k+1.
- Pop sampled at edge k+2 → data_out and valid_out update after edge k+2. Minimum write-to-output latency is 2 cycles.
- All status outputs are registered or derived combinationally from registered counts only; there is no combinational path from input to output.
- pause is advisory. The upstream stops within a bounded number of cycles; writes beyond capacity are dropped and flagged.
- Reset mid-operation discards all stored words at that edge and returns every output to its reset value.

## Structure
- Shared package full_logic_pkg holds:
  - default widths and depths;
  - the sel-extraction function;
  - the count-width constant.
- Sub-module fifo_sync:
  - parametrised by DATA_WIDTH, ADDR_WIDTH, AF_THRESH and AE_THRESH;
  - ports push, pop, din, dout_reg, full, empty, almost_full, almost_empty, overflow, underflow;
  - instantiated once for the main FIFO and NUM_CH times in a generate loop.
- The top level contains the transfer logic, pause OR-reduction and sticky error registers.

## Test plan
All scenarios use the defaults: select bits are data[5:4], depth 4.
- Reset: hold reset=1 for 3 cycles → empty=4'b1111, pause=0, all errors 0, data_out=0.
- Routing: write 6'b000001, 6'b010010, 6'b100011, 6'b110100 on consecutive cycles, then pop=4'b1111 → data_out slices = 01, 12, 23, 34 (hex), valid_out=4'b1111 for one cycle.
- Backpressure: write six ch0 words 6'b000001..6'b000110 with no pops → ch0 is full with 1..4, main holds 5,6, pause=1. Then pop ch0 six times → outputs 1..6 in order.
- Overflow and head-of-line blocking: with ch0 full, write 5 more ch0 words → the 5th is dropped and error_main=1. A following ch1 word stays blocked and empty[1]=1 until ch0 is popped.
- Underflow plus simultaneous events: pop ch2 while empty → error_ch[2]=1, valid_out[2]=0. In the same cycle, pop ch1 and transfer into ch1 → count unchanged.
- Reset mid-stream: reset while main and ch0 hold data → next cycle all FIFOs are empty and errors are 0. A subsequent write of 6'b100011 appears on ch2.
